spi_regbank_arb: RTL and testbench

Single-port 8-bit register bank shared between the SPI slave PHY and one on-chip local requester.
- Accepts PHY write strobes and address-captured read requests; returns read data on spi_rdata for the PHY's tx_data input.
- Arbitrates both SPI sources against a local req/gnt port with fixed SPI-read priority and a local anti-starvation rule.
- Sits between spi_phy and the fabric control/status logic.

---
 rtl/spi_regbank_pkg.sv | 20 ++
 rtl/spi_regbank_mem.sv | 44 ++++
 rtl/spi_regbank_arb.sv | 200 ++++++++++++++++++++
 tb/tb_spi_regbank_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared types and defaults for the SPI/local register bank arbiter.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPI_RD = 2'd1,
        SPI_WR = 2'd2,
        LOC    = 2'd3
    } state_e;

    localparam int          DEF_ADDR_W  = 7;
    localparam int          DEF_DATA_W  = 8;
    localparam logic [6:0]  DEF_RO_BASE = 7'h60;
    localparam logic [7:0]  DEF_RST_VAL = 8'h00;
    localparam int          RO_CLR_ADDR = 0;

    // 1: flop bank reset in place; 0: plain array initialised by a clear sweep
    localparam bit          USE_FLOP_BANK = 1'b1;

endpackage

// File: rtl/spi_regbank_mem.sv
// Single-port register array: one write or read per cycle, read is
// combinational so a read after a write sees the new value.
module spi_regbank_mem
    import spi_regbank_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = DEF_RST_VAL
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] bank_q [DEPTH];

    assign rdata = bank_q[addr];

    generate
        if (USE_FLOP_BANK) begin : g_flop
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        bank_q[i] <= RST_VAL;
                    end
                end else if (we) begin
                    bank_q[addr] <= wdata;
                end
            end
        end else begin : g_ram
            always_ff @(posedge clk) begin
                if (we) begin
                    bank_q[addr] <= wdata;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/spi_regbank_arb.sv
// SPI PHY / local requester arbiter over a single-port register bank.
// Optional SPI write IRQ and dirty tracking under `define SPI_WR_IRQ_EN.
module spi_regbank_arb
    import spi_regbank_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RO_BASE = DEF_RO_BASE,
    parameter logic [DATA_W-1:0] RST_VAL = DEF_RST_VAL
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_rd_req,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic              spi_wr_en,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_rvalid,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic              loc_rvalid,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              spi_ro_err
`ifdef SPI_WR_IRQ_EN
    ,
    output logic              spi_wr_irq,
    output logic [2**ADDR_W-1:0] spi_dirty
`endif
);

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic              loc_wait_q, loc_wait_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
    logic              spi_rvalid_q, spi_rvalid_d;
    logic              loc_gnt_q, loc_gnt_d;
    logic              loc_rvalid_q, loc_rvalid_d;
    logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
    logic              ro_err_q, ro_err_d;
    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic              rd_any, wr_any, loc_elig, loc_fair;
    logic              wr_ok, wr_ro;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    // Arbitration for the next cycle's access; live pulses count as pending.
    always_comb begin
        rd_any   = rd_pend_q | spi_rd_req;
        wr_any   = wr_pend_q | spi_wr_en;
        loc_elig = loc_req & (state_q != LOC);
        loc_fair = loc_elig & loc_wait_q &
                   ((state_q == SPI_RD) | (state_q == SPI_WR));
        state_d  = IDLE;
        priority case (1'b1)
            clr_busy_q: state_d = IDLE;
            rd_any:     state_d = SPI_RD;
            loc_fair:   state_d = LOC;
            wr_any:     state_d = SPI_WR;
            loc_elig:   state_d = LOC;
            default:    state_d = IDLE;
        endcase
        rd_pend_d  = rd_any & (state_d != SPI_RD);
        wr_pend_d  = wr_any & (state_d != SPI_WR);
        wr_addr_d  = spi_wr_en ? spi_addr : wr_addr_q;
        wr_data_d  = spi_wr_en ? spi_wdata : wr_data_q;
        loc_wait_d = loc_elig & (state_d != LOC);
        loc_gnt_d  = (state_d == LOC);
        clr_busy_d = clr_busy_q & (clr_cnt_q != '1);
        clr_cnt_d  = clr_busy_q ? clr_cnt_q + ADDR_W'(1) : clr_cnt_q;
    end

    // The access performed this cycle, selected by state_q.
    always_comb begin
        wr_ok     = (state_q == SPI_WR) & (wr_addr_q < RO_BASE);
        wr_ro     = (state_q == SPI_WR) & ~(wr_addr_q < RO_BASE);
        mem_we    = 1'b0;
        mem_addr  = spi_addr;
        mem_wdata = wr_data_q;
        case (state_q)
            SPI_WR: begin
                mem_addr = wr_addr_q;
                mem_we   = wr_ok;
            end
            LOC: begin
                mem_addr  = loc_addr;
                mem_we    = loc_we;
                mem_wdata = loc_wdata;
            end
            default: ;
        endcase
        if (clr_busy_q) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = RST_VAL;
        end
        spi_rvalid_d = (state_q == SPI_RD);
        spi_rdata_d  = spi_rvalid_d ? mem_rdata : spi_rdata_q;
        loc_rvalid_d = (state_q == LOC) & ~loc_we;
        loc_rdata_d  = loc_rvalid_d ? mem_rdata : loc_rdata_q;
        ro_err_d     = ro_err_q | wr_ro;
        if ((state_q == LOC) && loc_we &&
            (loc_addr == ADDR_W'(RO_CLR_ADDR))) begin
            ro_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_pend_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
            loc_wait_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            spi_rdata_q  <= '0;
            spi_rvalid_q <= 1'b0;
            loc_gnt_q    <= 1'b0;
            loc_rvalid_q <= 1'b0;
            loc_rdata_q  <= '0;
            ro_err_q     <= 1'b0;
            clr_busy_q   <= !USE_FLOP_BANK;
            clr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            wr_pend_q    <= wr_pend_d;
            loc_wait_q   <= loc_wait_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            spi_rdata_q  <= spi_rdata_d;
            spi_rvalid_q <= spi_rvalid_d;
            loc_gnt_q    <= loc_gnt_d;
            loc_rvalid_q <= loc_rvalid_d;
            loc_rdata_q  <= loc_rdata_d;
            ro_err_q     <= ro_err_d;
            clr_busy_q   <= clr_busy_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    spi_regbank_mem #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (mem_rdata)
    );

    assign spi_rdata  = spi_rdata_q;
    assign spi_rvalid = spi_rvalid_q;
    assign loc_gnt    = loc_gnt_q;
    assign loc_rvalid = loc_rvalid_q;
    assign loc_rdata  = loc_rdata_q;
    assign spi_ro_err = ro_err_q;

`ifdef SPI_WR_IRQ_EN
    logic                irq_q, irq_d;
    logic [2**ADDR_W-1:0] dirty_q, dirty_d;

    // Set after clear so a same-cycle set wins.
    always_comb begin
        irq_d   = wr_ok;
        dirty_d = dirty_q;
        if (loc_rvalid_d) begin
            dirty_d[loc_addr] = 1'b0;
        end
        if (wr_ok) begin
            dirty_d[wr_addr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q   <= 1'b0;
            dirty_q <= '0;
        end else begin
            irq_q   <= irq_d;
            dirty_q <= dirty_d;
        end
    end

    assign spi_wr_irq = irq_q;
    assign spi_dirty  = dirty_q;
`endif

endmodule

// File: tb/tb_spi_regbank_arb.sv
// Bench for spi_regbank_arb: directed scenarios plus random single ops
// checked against an array model of the bank (also builds with SPI_WR_IRQ_EN).
module tb_spi_regbank_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_rd_req, spi_wr_en, loc_req, loc_we;
    logic [6:0] spi_addr, loc_addr;
    logic [7:0] spi_wdata, loc_wdata, spi_rdata, loc_rdata;
    logic       spi_rvalid, loc_gnt, loc_rvalid, spi_ro_err;
`ifdef SPI_WR_IRQ_EN
    logic         spi_wr_irq;
    logic [127:0] spi_dirty;
    logic [127:0] ref_dirty;
    int           irq_cnt = 0;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] ref_bank [128];
    logic       ref_err;

    always #5 clk = ~clk;

    spi_regbank_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_rd_req (spi_rd_req),
        .spi_addr   (spi_addr),
        .spi_wr_en  (spi_wr_en),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .spi_rvalid (spi_rvalid),
        .loc_req    (loc_req),
        .loc_we     (loc_we),
        .loc_addr   (loc_addr),
        .loc_wdata  (loc_wdata),
        .loc_gnt    (loc_gnt),
        .loc_rvalid (loc_rvalid),
        .loc_rdata  (loc_rdata),
        .spi_ro_err (spi_ro_err)
`ifdef SPI_WR_IRQ_EN
        ,
        .spi_wr_irq (spi_wr_irq),
        .spi_dirty  (spi_dirty)
`endif
    );

`ifdef SPI_WR_IRQ_EN
    always @(negedge clk) begin
        if (spi_wr_irq === 1'b1) irq_cnt <= irq_cnt + 1;
    end
`endif

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) ref_bank[i] = 8'h00;
        ref_err = 1'b0;
`ifdef SPI_WR_IRQ_EN
        ref_dirty = '0;
`endif
    endtask

    task automatic spi_read(input logic [6:0] a, input string tag);
        int         lat = 99;
        logic [7:0] d   = 'x;
        spi_addr   = a;
        spi_rd_req = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 1) spi_rd_req = 1'b0;
            if (spi_rvalid && lat == 99) begin
                lat = n;
                d   = spi_rdata;
            end
        end
        check({tag, "_lat"}, 128'(lat >= 1 && lat <= 2), 128'(1));
        check({tag, "_data"}, 128'(d), 128'(ref_bank[a]));
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d,
                             input string tag);
`ifdef SPI_WR_IRQ_EN
        int before;
        before = irq_cnt;
`endif
        spi_addr  = a;
        spi_wdata = d;
        spi_wr_en = 1'b1;
        tick();
        spi_wr_en = 1'b0;
        tick();
        tick();
        if (a < 7'h60) ref_bank[a] = d;
        else           ref_err = 1'b1;
`ifdef SPI_WR_IRQ_EN
        if (a < 7'h60) ref_dirty[a] = 1'b1;
        check({tag, "_irq"}, 128'(irq_cnt - before), 128'(a < 7'h60));
        check({tag, "_dirty"}, spi_dirty, ref_dirty);
`endif
        check({tag, "_roerr"}, 128'(spi_ro_err), 128'(ref_err));
    endtask

    task automatic loc_op(input logic we, input logic [6:0] a,
                          input logic [7:0] d, input string tag);
        logic got = 1'b0;
        loc_we    = we;
        loc_addr  = a;
        loc_wdata = d;
        loc_req   = 1'b1;
        for (int n = 1; n <= 8 && !got; n++) begin
            tick();
            if (loc_gnt) got = 1'b1;
        end
        check({tag, "_gnt"}, 128'(got), 128'(1));
        tick();
        loc_req = 1'b0;
        if (we) begin
            ref_bank[a] = d;
            if (a == 7'h00) ref_err = 1'b0;
        end else begin
            check({tag, "_rvalid"}, 128'(loc_rvalid), 128'(1));
            check({tag, "_rdata"}, 128'(loc_rdata), 128'(ref_bank[a]));
`ifdef SPI_WR_IRQ_EN
            ref_dirty[a] = 1'b0;
`endif
        end
        tick();
        check({tag, "_roerr"}, 128'(spi_ro_err), 128'(ref_err));
`ifdef SPI_WR_IRQ_EN
        check({tag, "_dirty"}, spi_dirty, ref_dirty);
`endif
    endtask

    initial begin
        int         g, rv, lrv, op;
        logic [7:0] ds, dl;
        logic [6:0] a;

        reset_n    = 1'b0;
        spi_rd_req = 1'b0;
        spi_wr_en  = 1'b0;
        loc_req    = 1'b0;
        loc_we     = 1'b0;
        spi_addr   = '0;
        loc_addr   = '0;
        spi_wdata  = '0;
        loc_wdata  = '0;
        model_reset();
        tick();
        check("reset_outs", 128'({spi_rdata, spi_rvalid, loc_gnt,
              loc_rvalid, loc_rdata, spi_ro_err}), 128'(0));
        tick();
        reset_n = 1'b1;
        tick();

        spi_read(7'h05, "t1_rd05");

        spi_write(7'h10, 8'hA5, "t2_wr10");
        spi_read(7'h10, "t2_rd10");
        loc_op(1'b0, 7'h10, 8'h00, "t2_lrd10");

        spi_write(7'h60, 8'h3C, "t3_wr60");
        loc_op(1'b0, 7'h60, 8'h00, "t3_lrd60");
        loc_op(1'b1, 7'h60, 8'h77, "t3_lwr60");
        loc_op(1'b0, 7'h60, 8'h00, "t3_lrd60b");
        spi_write(7'h5F, 8'h99, "t3_wr5f");
        spi_read(7'h5F, "t3_rd5f");
        loc_op(1'b1, 7'h00, 8'h01, "t3_clr");

        // Concurrent RD + WR + local read: expected service RD, LOC, WR.
        loc_op(1'b1, 7'h20, 8'h4B, "t4_init");
        spi_addr   = 7'h20;
        spi_wdata  = 8'hB4;
        spi_rd_req = 1'b1;
        spi_wr_en  = 1'b1;
        loc_we     = 1'b0;
        loc_addr   = 7'h20;
        loc_req    = 1'b1;
        g = 0; rv = 0; lrv = 0; ds = 'x; dl = 'x;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) begin
                spi_rd_req = 1'b0;
                spi_wr_en  = 1'b0;
            end
            if (spi_rvalid && rv == 0) begin
                rv = n;
                ds = spi_rdata;
            end
            if (loc_rvalid && lrv == 0) begin
                lrv = n;
                dl  = loc_rdata;
            end
            if (loc_gnt && g == 0) g = n;
            else if (g != 0) loc_req = 1'b0;
        end
        loc_req = 1'b0;
        check("t4_rv_lat", 128'(rv >= 1 && rv <= 2), 128'(1));
        check("t4_gnt_lat", 128'(g >= 1 && g <= 2), 128'(1));
        check("t4_rd_before_loc", 128'(rv <= g), 128'(1));
        check("t4_lrv_lat", 128'(lrv), 128'(g + 1));
        check("t4_spi_old", 128'(ds), 128'(8'h4B));
        check("t4_loc_old", 128'(dl), 128'(8'h4B));
        ref_bank[7'h20] = 8'hB4;
`ifdef SPI_WR_IRQ_EN
        ref_dirty[7'h20] = 1'b1;
`endif
        spi_read(7'h20, "t4_rd20");

        // Same-address SPI and local writes: local value is final.
`ifdef SPI_WR_IRQ_EN
        op = irq_cnt;
`endif
        spi_addr  = 7'h30;
        spi_wdata = 8'h11;
        spi_wr_en = 1'b1;
        loc_we    = 1'b1;
        loc_addr  = 7'h30;
        loc_wdata = 8'h22;
        loc_req   = 1'b1;
        g = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) spi_wr_en = 1'b0;
            if (loc_gnt && g == 0) g = n;
            else if (g != 0) loc_req = 1'b0;
        end
        loc_req = 1'b0;
        check("t5_gnt", 128'(g != 0), 128'(1));
        ref_bank[7'h30] = 8'h22;
`ifdef SPI_WR_IRQ_EN
        ref_dirty[7'h30] = 1'b1;
        check("t5_irq_once", 128'(irq_cnt - op), 128'(1));
        check("t5_dirty48", 128'(spi_dirty[48]), 128'(1));
`endif
        spi_read(7'h30, "t5_rd30");
        loc_op(1'b0, 7'h30, 8'h00, "t5_lrd30");

        // Random single operations against the model.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            a  = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) a = 7'(8'h5E + $urandom_range(0, 3));
            case (op)
                0: spi_write(a, 8'($urandom), "rnd_swr");
                1: spi_read(a, "rnd_srd");
                2: loc_op(1'b1, a, 8'($urandom), "rnd_lwr");
                default: loc_op(1'b0, a, 8'h00, "rnd_lrd");
            endcase
        end

        // Reset during a pending SPI write.
        spi_write(7'h10, 8'hA5, "t6_wr10");
        spi_read(7'h10, "t6_rd10");
        spi_write(7'h70, 8'h01, "t6_wr70");
        spi_addr  = 7'h10;
        spi_wdata = 8'hEE;
        spi_wr_en = 1'b1;
        tick();
        spi_wr_en = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("t6_async_outs", 128'({spi_rdata, spi_rvalid, loc_gnt,
              loc_rvalid, loc_rdata, spi_ro_err}), 128'(0));
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
        spi_read(7'h10, "t6_rd10_after");
        check("t6_roerr", 128'(spi_ro_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
